fifo_rd_ctrl: RTL
=================

// Module: fifo_rd_ctrl
// PURPOSE
//  Read-side controller for the gray-pointer FIFO, for the read clock domain. Generalised successor of the
//  read-pointer/empty block. Generates the binary RAM read address, the gray read pointer for the
//  write-domain synchroniser, registered empty/almost-empty flags, and a registered fill level.
//  Sits between the 2-FF wptr synchroniser (R2q_wptr) and the dual-port FIFO RAM read port.
// PARAMETERS
//  ADDR_W     3   RAM address width; DEPTH = 2**ADDR_W; pointers are ADDR_W+1 bits
//  AE_RST_THR 1   reset value of the almost-empty threshold register (0..DEPTH)
// PORTS
//  Rclk          in   1         read-domain clock, all state on rising edge
//  Rrst          in   1         synchronous reset, active-high
//  Rinc          in   1         read request
//  R2q_wptr      in   ADDR_W+1  write pointer (gray), already synchronised into Rclk
//  Rae_thr       in   ADDR_W+1  almost-empty threshold, sampled every cycle
//  Rae_thr_ld    in   1         1 = load Rae_thr into threshold register
//  Radder        out  ADDR_W    binary RAM read address (registered)
//  Rptr          out  ADDR_W+1  gray read pointer to write domain (registered)
//  Rpop          out  1         read accepted this cycle = Rinc & ~Rempty (combinational)
//  Rempty        out  1         FIFO empty (registered)
//  Ralmost_empty out  1         level <= threshold (registered)
//  Rlevel        out  ADDR_W+1  entries visible to reader, 0..DEPTH (registered)
//  Runderflow    out  1         sticky read-while-empty error (only with FIFO_RD_UNDERFLOW_EN)
// BEHAVIOUR
//  - Reset (Rrst=1 at Rclk edge, overrides all): rbin=0, Rptr=0, Radder=0, Rempty=1, Ralmost_empty=1,
//    Rlevel=0, threshold=AE_RST_THR, Runderflow=0. Mid-operation reset discards state in one cycle.
//  - rbin_next = rbin + Rpop (mod 2**(ADDR_W+1)); rgray_next = (rbin_next>>1) ^ rbin_next.
//  - Each edge: rbin<=rbin_next, Rptr<=rgray_next, Radder = rbin[ADDR_W-1:0] (full ADDR_W width).
//  - wbin = gray2bin(R2q_wptr); level_next = wbin - rbin_next, ADDR_W+1 bit modulo arithmetic.
//  - Rempty <= (rgray_next == R2q_wptr); Rlevel <= level_next; Ralmost_empty <= (level_next <= thr).
//    All flags reflect the pop of the current cycle: one-cycle latency, no bubble.
//  - Rinc while Rempty=1: ignored (pointers hold, Rpop=0); underflow flag per CONFIGURATION.
//  - Pop of last entry: Rempty=1 and Rlevel=0 on the next edge unless R2q_wptr advanced.
//  - Wrap: rbin rolls from 2**(ADDR_W+1)-1 to 0; Radder rolls from DEPTH-1 to 0; level stays correct.
//  - Simultaneous pop and R2q_wptr change: both folded into the same level_next/Rempty evaluation.
//  - Rae_thr_ld: new threshold used from the following cycle's flag calculation; values > DEPTH
//    saturate to DEPTH (Ralmost_empty then permanently 1).
//  - Rlevel never exceeds DEPTH given a legal synchroniser; no clamping in RTL, checked by assertion.
// CONFIGURATION
//  FIFO_RD_UNDERFLOW_EN defined: Runderflow port present; set on any cycle with Rinc & Rempty,
//    held until Rrst. Undefined: port absent, read-while-empty silently ignored, no other change.
// STRUCTURE
//  - fifo_pkg: bin2gray/gray2bin functions (width-generic), shared with write-side controller.
//  - Sub-module fifo_gray2bin #(W) converts R2q_wptr; reused by write side for the rptr.
//  - Everything else flat: one seq block (pointers/flags/threshold), one comb block (next-state).
// TESTING (ADDR_W=3, DEPTH=8, AE_RST_THR=1)
//  1 Reset, R2q_wptr=0, Rinc=1 10 cycles -> Rempty=1, Radder=0, Rptr=0, Rpop=0; Runderflow=1 if _EN.
//  2 R2q_wptr=gray(8)=4'b1100, Rinc=0 -> next edge Rempty=0, Rlevel=8, Ralmost_empty=0.
//  3 From 2, Rinc=1 8 cycles -> Radder 0..7 then 0, Rlevel 7..0, Ralmost_empty=1 once Rlevel<=1,
//    Rempty=1 after 8th pop, Rptr=4'b1100.
//  4 Wrap: 20 fill/drain rounds of 5 entries -> rbin wraps 15->0, Rptr always gray(rbin), no false empty.
//  5 Rae_thr=4 with Rae_thr_ld=1, level 5 then pop -> Ralmost_empty 0 then 1 the edge after the pop.
//  6 Rrst=1 mid-drain at level 3 -> next edge all outputs at reset values, Runderflow cleared.

Source files
------------

// File: rtl/fifo_pkg.sv
// Gray/binary pointer helpers shared by the read- and write-side FIFO controllers.
// Functions work on a wide word; zero-extend narrower pointers in and size-cast the result out.
package fifo_pkg;

  localparam int PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Leading zeros of a zero-extended gray code decode to leading zeros, so any width <= PTR_MAX_W works
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO controller bus: reader request, synchronised write pointer, RAM address and flags.
// Runderflow exists only when FIFO_RD_UNDERFLOW_EN is defined.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_W = 3
);

  logic              Rinc;
  logic [ADDR_W:0]   R2q_wptr;
  logic [ADDR_W:0]   Rae_thr;
  logic              Rae_thr_ld;
  logic [ADDR_W-1:0] Radder;
  logic [ADDR_W:0]   Rptr;
  logic              Rpop;
  logic              Rempty;
  logic              Ralmost_empty;
  logic [ADDR_W:0]   Rlevel;
`ifdef FIFO_RD_UNDERFLOW_EN
  logic              Runderflow;

  modport master (
    output Rinc, R2q_wptr, Rae_thr, Rae_thr_ld,
    input  Radder, Rptr, Rpop, Rempty, Ralmost_empty, Rlevel, Runderflow
  );

  modport slave (
    input  Rinc, R2q_wptr, Rae_thr, Rae_thr_ld,
    output Radder, Rptr, Rpop, Rempty, Ralmost_empty, Rlevel, Runderflow
  );
`else
  modport master (
    output Rinc, R2q_wptr, Rae_thr, Rae_thr_ld,
    input  Radder, Rptr, Rpop, Rempty, Ralmost_empty, Rlevel
  );

  modport slave (
    input  Rinc, R2q_wptr, Rae_thr, Rae_thr_ld,
    output Radder, Rptr, Rpop, Rempty, Ralmost_empty, Rlevel
  );
`endif

endinterface

// File: rtl/fifo_gray2bin.sv
// Width-generic gray-to-binary converter; read side decodes the write pointer, write side the read pointer.
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign bin[gi] = ^gray[W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the gray-pointer FIFO: read address, gray pointer, empty/almost-empty, level.
// Define FIFO_RD_UNDERFLOW_EN to add the sticky Runderflow flag.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int AE_RST_THR = 1
) (
  input  logic          Rclk,
  input  logic          Rrst,
  fifo_rd_ctrl_if.slave rd
);

  localparam int unsigned   DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] THR_RST = (ADDR_W+1)'(AE_RST_THR);

  logic [ADDR_W:0]   rbin_reg;
  logic [ADDR_W:0]   rbin_next;
  logic [ADDR_W:0]   rgray_next;
  logic [ADDR_W:0]   rptr_reg;
  logic [ADDR_W-1:0] radder_reg;
  logic [ADDR_W:0]   wbin;
  logic [ADDR_W:0]   level_reg;
  logic [ADDR_W:0]   level_next;
  logic [ADDR_W:0]   thr_reg;
  logic [ADDR_W:0]   thr_next;
  logic              empty_reg;
  logic              empty_next;
  logic              ae_reg;
  logic              ae_next;
  logic              rpop;

  fifo_gray2bin #(
    .W (ADDR_W + 1)
  ) u_wptr_g2b (
    .gray (rd.R2q_wptr),
    .bin  (wbin)
  );

  // Flags are evaluated on the post-pop pointer so they never lag the read by a cycle
  always_comb begin
    rpop       = rd.Rinc & ~empty_reg;
    rbin_next  = rbin_reg + {{ADDR_W{1'b0}}, rpop};
    rgray_next = (ADDR_W+1)'(bin2gray(ptr_word_t'(rbin_next)));
    level_next = wbin - rbin_next;
    empty_next = (rgray_next == rd.R2q_wptr);
    ae_next    = (level_next <= thr_reg);
    thr_next   = thr_reg;
    if (rd.Rae_thr_ld) begin
      thr_next = (rd.Rae_thr > DEPTH_V) ? DEPTH_V : rd.Rae_thr;
    end
  end

  always_ff @(posedge Rclk) begin
    if (Rrst) begin
      rbin_reg   <= '0;
      rptr_reg   <= '0;
      radder_reg <= '0;
      empty_reg  <= 1'b1;
      ae_reg     <= 1'b1;
      level_reg  <= '0;
      thr_reg    <= THR_RST;
    end else begin
      rbin_reg   <= rbin_next;
      rptr_reg   <= rgray_next;
      radder_reg <= rbin_next[ADDR_W-1:0];
      empty_reg  <= empty_next;
      ae_reg     <= ae_next;
      level_reg  <= level_next;
      thr_reg    <= thr_next;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  logic underflow_reg;

  always_ff @(posedge Rclk) begin
    if (Rrst) begin
      underflow_reg <= 1'b0;
    end else if (rd.Rinc & empty_reg) begin
      underflow_reg <= 1'b1;
    end
  end

  assign rd.Runderflow = underflow_reg;
`endif

  assign rd.Radder        = radder_reg;
  assign rd.Rptr          = rptr_reg;
  assign rd.Rpop          = rpop;
  assign rd.Rempty        = empty_reg;
  assign rd.Ralmost_empty = ae_reg;
  assign rd.Rlevel        = level_reg;

`ifndef SYNTHESIS
  // A level above DEPTH means the synchronised write pointer is corrupt, not a FIFO state
  level_bound_a: assert property (@(posedge Rclk) disable iff (Rrst) level_reg <= DEPTH_V);
`endif

endmodule
